// File: rtl/uart_rx_monitor_if.sv
// Byte-stream and status bundle between the UART RX monitor (master) and its consumer (slave).
// parity_err exists only when UART_MON_PARITY_EN is defined.
interface uart_rx_monitor_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          rx;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [LW-1:0] fifo_level;
  logic          frame_err;
  logic          ovf;
  logic          clr_err;
`ifdef UART_MON_PARITY_EN
  logic          parity_err;

  modport master (
    input  rx, rd_ready, clr_err,
    output rd_data, rd_valid, fifo_level, frame_err, ovf, parity_err
  );
  modport slave (
    output rx, rd_ready, clr_err,
    input  rd_data, rd_valid, fifo_level, frame_err, ovf, parity_err
  );
`else
  modport master (
    input  rx, rd_ready, clr_err,
    output rd_data, rd_valid, fifo_level, frame_err, ovf
  );
  modport slave (
    output rx, rd_ready, clr_err,
    input  rd_data, rd_valid, fifo_level, frame_err, ovf
  );
`endif
endinterface

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver into a FWFT byte FIFO; byte visible 1 cycle after the stop-bit sample, dropped (ovf) when full.
// UART_MON_PARITY_EN adds an even-parity bit between data and stop plus a sticky parity_err.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 8
) (
  input logic               HCLK,
  input logic               HRESET,
  uart_rx_monitor_if.master mon
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          rx_meta_q, rxs_q, rxs_prev_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          frame_err_q, ovf_q;
  logic          push, frame_evt, full, rd_vld, do_pop, do_push, ovf_evt;
`ifdef UART_MON_PARITY_EN
  logic          parity_err_q, par_evt;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bidx_d    = bidx_q;
    shift_d   = shift_q;
    push      = 1'b0;
    frame_evt = 1'b0;
`ifdef UART_MON_PARITY_EN
    par_evt   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) state_d = START;
      end
      // Mid-start-bit recheck rejects short glitches without flagging anything.
      START: if (cnt_q == HALF) begin
        cnt_d   = '0;
        bidx_d  = '0;
        state_d = rxs_q ? IDLE : DATA;
      end
      DATA: if (cnt_q == LAST) begin
        cnt_d   = '0;
        shift_d = {rxs_q, shift_q[7:1]};
        bidx_d  = bidx_q + 3'd1;
        if (bidx_q == 3'd7) begin
`ifdef UART_MON_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_MON_PARITY_EN
      PARITY: if (cnt_q == LAST) begin
        cnt_d   = '0;
        par_evt = ^{shift_q, rxs_q};
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == LAST) begin
        cnt_d = '0;
        if (rxs_q) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_evt = 1'b1;
          state_d   = BRK;
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign rd_vld  = (level_q != '0);
  assign do_pop  = rd_vld & mon.rd_ready;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign ovf_evt = push & full & ~do_pop;
  assign level_d = level_q + LW'(do_push) - LW'(do_pop);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      rx_meta_q   <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= IDLE;
      cnt_q       <= '0;
      bidx_q      <= '0;
      shift_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
`ifdef UART_MON_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta_q   <= mon.rx;
      rxs_q       <= rx_meta_q;
      rxs_prev_q  <= rxs_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bidx_q      <= bidx_d;
      shift_q     <= shift_d;
      level_q     <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      frame_err_q <= frame_evt | (frame_err_q & ~mon.clr_err);
      ovf_q       <= ovf_evt | (ovf_q & ~mon.clr_err);
`ifdef UART_MON_PARITY_EN
      parity_err_q <= par_evt | (parity_err_q & ~mon.clr_err);
`endif
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign mon.rd_data    = rd_vld ? mem_q[rd_ptr_q] : 8'h00;
  assign mon.rd_valid   = rd_vld;
  assign mon.fifo_level = level_q;
  assign mon.frame_err  = frame_err_q;
  assign mon.ovf        = ovf_q;
`ifdef UART_MON_PARITY_EN
  assign mon.parity_err = parity_err_q;
`endif
endmodule

// File: tb/tb_uart_rx_monitor.sv
// Directed bench for uart_rx_monitor: reset, latency, glitch, framing/break, overflow, mid-frame reset.
// Build with +define+UART_MON_PARITY_EN to also exercise the parity bit.
module tb_uart_rx_monitor;
  localparam int CPB   = 16;
  localparam int DEPTH = 8;
`ifdef UART_MON_PARITY_EN
  localparam int PUSH_LAT = 170;
`else
  localparam int PUSH_LAT = 154;
`endif

  logic HCLK   = 1'b0;
  logic HRESET = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_rx_monitor_if #(.FIFO_DEPTH(DEPTH)) mon ();

  uart_rx_monitor #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .mon   (mon)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    mon.rx = b;
    repeat (CPB) @(posedge HCLK);
    #1;
  endtask

  // Line is left at the stop-bit level so a forced-low stop bit becomes a break.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_bad);
    @(posedge HCLK);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_MON_PARITY_EN
    drive_bit((^d) ^ par_bad);
`else
    if (par_bad) mon.rx = 1'b1;
`endif
    drive_bit(stop_b);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    chk({tag, "_vld"}, mon.rd_valid, 1);
    chk({tag, "_dat"}, mon.rd_data, exp);
    mon.rd_ready = 1'b1;
    @(posedge HCLK);
    #1;
    mon.rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    mon.clr_err = 1'b1;
    @(posedge HCLK);
    #1;
    mon.clr_err = 1'b0;
  endtask

  initial begin
    mon.rx       = 1'b1;
    mon.rd_ready = 1'b0;
    mon.clr_err  = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("rst_valid", mon.rd_valid, 0);
    chk("rst_level", mon.fifo_level, 0);
    chk("rst_frame", mon.frame_err, 0);
    chk("rst_ovf", mon.ovf, 0);
    chk("rst_data", mon.rd_data, 0);
    HRESET = 1'b0;
    repeat (5) @(posedge HCLK);
    #1;

    // Single byte with push-latency probe
    fork
      send_frame(8'h48, 1'b1, 1'b0);
      begin
        repeat (PUSH_LAT + 1) @(posedge HCLK);
        #1;
        chk("lat_before", mon.rd_valid, 0);
        @(posedge HCLK);
        #1;
        chk("lat_after", mon.rd_valid, 1);
      end
    join
    chk("one_level", mon.fifo_level, 1);
    pop_check("one", 8'h48);
    chk("one_level0", mon.fifo_level, 0);
    chk("one_empty", mon.rd_valid, 0);
`ifdef UART_MON_PARITY_EN
    chk("one_par", mon.parity_err, 0);
`endif

    // Short glitch
    mon.rx = 1'b0;
    repeat (5) @(posedge HCLK);
    #1;
    mon.rx = 1'b1;
    repeat (30) @(posedge HCLK);
    #1;
    chk("glitch_valid", mon.rd_valid, 0);
    chk("glitch_level", mon.fifo_level, 0);
    chk("glitch_frame", mon.frame_err, 0);
    chk("glitch_ovf", mon.ovf, 0);

    // Framing error followed by a long break
    send_frame(8'h55, 1'b0, 1'b0);
    chk("frm_flag", mon.frame_err, 1);
    repeat (300) @(posedge HCLK);
    #1;
    chk("frm_level", mon.fifo_level, 0);
    chk("frm_valid", mon.rd_valid, 0);
    mon.rx = 1'b1;
    repeat (20) @(posedge HCLK);
    #1;
    send_frame(8'h31, 1'b1, 1'b0);
    repeat (4) @(posedge HCLK);
    #1;
    chk("frm_sticky", mon.frame_err, 1);
    pop_check("after_brk", 8'h31);
    pulse_clr();
    chk("frm_clr", mon.frame_err, 0);

    // Overflow: 9 bytes into 8 entries
    for (int i = 0; i < 8; i++) send_frame(8'(i), 1'b1, 1'b0);
    chk("ovf_level8", mon.fifo_level, 8);
    chk("ovf_pre", mon.ovf, 0);
    send_frame(8'h08, 1'b1, 1'b0);
    chk("ovf_level", mon.fifo_level, 8);
    chk("ovf_flag", mon.ovf, 1);
    for (int i = 0; i < 8; i++) pop_check("ovf_pop", 8'(i));
    chk("ovf_drained", mon.rd_valid, 0);
    pulse_clr();
    chk("ovf_clr", mon.ovf, 0);

    // Full FIFO with a pop coinciding with the 9th push
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    fork
      send_frame(8'h18, 1'b1, 1'b0);
      begin
        repeat (PUSH_LAT + 1) @(posedge HCLK);
        #1;
        mon.rd_ready = 1'b1;
        @(posedge HCLK);
        #1;
        mon.rd_ready = 1'b0;
      end
    join
    chk("pp_level", mon.fifo_level, 8);
    chk("pp_ovf", mon.ovf, 0);
    for (int i = 1; i < 9; i++) pop_check("pp_pop", 8'h10 + 8'(i));
    chk("pp_level0", mon.fifo_level, 0);

    // Reset in the middle of 0xA5, with a byte already queued
    send_frame(8'h66, 1'b1, 1'b0);
    chk("mid_pre", mon.fifo_level, 1);
    @(posedge HCLK);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] == 1'b0 ? 1'b1 : (i == 2));
    mon.rx = 1'b0;
    repeat (8) @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    #1;
    chk("mid_level", mon.fifo_level, 0);
    chk("mid_valid", mon.rd_valid, 0);
    mon.rx = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    repeat (20) @(posedge HCLK);
    #1;
    send_frame(8'h3C, 1'b1, 1'b0);
    repeat (4) @(posedge HCLK);
    #1;
    chk("mid_level1", mon.fifo_level, 1);
    pop_check("mid_3c", 8'h3C);
    chk("mid_frame", mon.frame_err, 0);

`ifdef UART_MON_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (4) @(posedge HCLK);
    #1;
    chk("par_flag", mon.parity_err, 1);
    pop_check("par_07", 8'h07);
    pulse_clr();
    chk("par_clr", mon.parity_err, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
